// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard/sequencing controller: load-use, branch flush, mult/div busy tracking
module hazard_ctrl #(
  parameter int unsigned MD_LATENCY  = 32,
  parameter logic [13:0] BUBBLE_CTRL = 14'h0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_ex_memread,
  input  logic [4:0]  id_ex_rt,
  input  logic [4:0]  if_id_rs,
  input  logic [4:0]  if_id_rt,
  input  logic        if_id_uses_rt,
  input  logic        branch_taken,
  input  logic        md_start,
  input  logic        if_id_md_use,
  input  logic [13:0] ctrl_in,
  input  logic        stall_clr,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic [13:0] id_ex_ctrl,
  output logic        md_busy,
  output logic        md_done,
  output logic [15:0] stall_cnt
);

  typedef enum logic {RUN, MD_BUSY} state_t;

  localparam logic [5:0] MD_LOAD = 6'(MD_LATENCY - 1);

  state_t      state_q, state_d;
  logic [5:0]  md_cnt_q, md_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        load_hz, md_hz, stall, md_issue;

  assign load_hz = id_ex_memread & (id_ex_rt != 5'd0) &
                   ((id_ex_rt == if_id_rs) | (if_id_uses_rt & (id_ex_rt == if_id_rt)));

  always_comb begin
    md_busy     = (state_q == MD_BUSY);
    md_done     = md_busy & (md_cnt_q == 6'd0);
    md_hz       = md_busy & if_id_md_use & ~md_done;
    stall       = md_hz | load_hz;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_ctrl  = ctrl_in;
    md_issue    = 1'b0;
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;

    // Reset low freezes the front end and keeps bubbles flowing into ID/EX.
    if (!reset) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_ctrl  = BUBBLE_CTRL;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_ctrl  = BUBBLE_CTRL;
    end else if (stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_ctrl  = BUBBLE_CTRL;
    end else begin
      md_issue = (state_q == RUN) & md_start;
    end

    case (state_q)
      RUN: begin
        if (md_issue) begin
          state_d  = MD_BUSY;
          md_cnt_d = MD_LOAD;
        end
      end
      MD_BUSY: begin
        if (md_cnt_q == 6'd0) begin
          state_d = RUN;
        end else begin
          md_cnt_d = md_cnt_q - 6'd1;
        end
      end
      default: state_d = RUN;
    endcase

    stall_cnt_d = stall_cnt_q;
    if (stall_clr) begin
      stall_cnt_d = 16'd0;
    end else if (!if_id_write && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      md_cnt_q    <= 6'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam logic [13:0] CI  = 14'h2ABC;
  localparam logic [13:0] BUB = 14'h0001;
  localparam logic [4:0] PASS  = 5'b11000;
  localparam logic [4:0] STALL = 5'b00000;
  localparam logic [4:0] FLUSH = 5'b11100;
  localparam logic [4:0] BUSY  = 5'b00010;
  localparam logic [4:0] DONE  = 5'b00001;

  typedef struct packed {
    logic       mr;
    logic [4:0] ex_rt, rs, rt;
    logic       ur, br, mds, mdu, clr;
  } stim_t;

  typedef struct packed {
    logic        pcw, ifw, fl;
    logic [13:0] ctrl;
    logic        busy, done;
    logic [15:0] sc;
  } obs_t;

  typedef struct packed {
    stim_t      s;
    logic [4:0] e;
  } row_t;

  logic        clk, reset;
  logic        id_ex_memread, if_id_uses_rt, branch_taken, md_start, if_id_md_use, stall_clr;
  logic [4:0]  id_ex_rt, if_id_rs, if_id_rt;
  logic [13:0] ctrl_in, id_ex_ctrl;
  logic        pc_write, if_id_write, if_id_flush, md_busy, md_done;
  logic [15:0] stall_cnt;

  obs_t        q[$];
  logic [15:0] exp_sc;
  int          n_checks, n_err;

  hazard_ctrl #(.MD_LATENCY(4), .BUBBLE_CTRL(14'h0001)) dut (
    .clk(clk), .reset(reset),
    .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .branch_taken(branch_taken), .md_start(md_start), .if_id_md_use(if_id_md_use),
    .ctrl_in(ctrl_in), .stall_clr(stall_clr),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_ctrl(id_ex_ctrl), .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic stim_t st(logic mr, logic [4:0] ex_rt, logic [4:0] rs, logic [4:0] rt,
                               logic ur, logic br, logic mds, logic mdu, logic clr);
    stim_t s;
    s = '{mr, ex_rt, rs, rt, ur, br, mds, mdu, clr};
    return s;
  endfunction

  function automatic row_t r(stim_t s, logic [4:0] e);
    row_t x;
    x.s = s;
    x.e = e;
    return x;
  endfunction

  function automatic obs_t obs();
    obs_t o;
    o = {pc_write, if_id_write, if_id_flush, id_ex_ctrl, md_busy, md_done, stall_cnt};
    return o;
  endfunction

  task automatic apply(stim_t s);
    id_ex_memread = s.mr;
    id_ex_rt      = s.ex_rt;
    if_id_rs      = s.rs;
    if_id_rt      = s.rt;
    if_id_uses_rt = s.ur;
    branch_taken  = s.br;
    md_start      = s.mds;
    if_id_md_use  = s.mdu;
    stall_clr     = s.clr;
    ctrl_in       = CI;
  endtask

  // Expected output for the cycle goes on the scoreboard; the counter model follows.
  task automatic predict(logic [4:0] e, logic clr);
    obs_t x;
    if (!reset) exp_sc = 16'd0;
    x = '{e[4], e[3], e[2], (e[3] & ~e[2]) ? CI : BUB, e[1], e[0], exp_sc};
    q.push_back(x);
    if (!reset || clr) exp_sc = 16'd0;
    else if (!e[3] && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
  endtask

  task automatic test_reset();
    row_t rows[$];
    obs_t got, ex;
    rows = '{r(st(1, 5, 5, 0, 0, 1, 1, 1, 0), STALL), r(st(0, 0, 0, 0, 0, 0, 0, 0, 0), STALL),
             r(st(0, 0, 0, 0, 0, 0, 0, 0, 0), PASS), r(st(0, 3, 4, 5, 1, 0, 0, 0, 0), PASS)};
    foreach (rows[i]) begin
      reset = (i >= 2);
      apply(rows[i].s);
      predict(rows[i].e, rows[i].s.clr);
      @(negedge clk);
      got = obs();
      ex = q.pop_front();
      n_checks++;
      if (got !== ex) begin
        n_err++;
        $display("FAIL reset[%0d] got=%h exp=%h", i, got, ex);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    row_t rows[$];
    obs_t got, ex;
    rows = '{r(st(1, 5, 5, 0, 0, 0, 0, 0, 0), STALL), r(st(0, 5, 5, 0, 0, 0, 0, 0, 0), PASS),
             r(st(1, 9, 3, 9, 1, 0, 0, 0, 0), STALL), r(st(0, 9, 3, 9, 1, 0, 0, 0, 0), PASS)};
    foreach (rows[i]) begin
      apply(rows[i].s);
      predict(rows[i].e, rows[i].s.clr);
      @(negedge clk);
      got = obs();
      ex = q.pop_front();
      n_checks++;
      if (got !== ex) begin
        n_err++;
        $display("FAIL load_use[%0d] got=%h exp=%h", i, got, ex);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_no_stall();
    row_t rows[$];
    obs_t got, ex;
    rows = '{r(st(1, 0, 0, 0, 1, 0, 0, 0, 0), PASS), r(st(1, 7, 3, 7, 0, 0, 0, 0, 0), PASS),
             r(st(1, 7, 3, 7, 1, 0, 0, 0, 0), STALL), r(st(0, 7, 3, 7, 1, 0, 0, 0, 0), PASS)};
    foreach (rows[i]) begin
      apply(rows[i].s);
      predict(rows[i].e, rows[i].s.clr);
      @(negedge clk);
      got = obs();
      ex = q.pop_front();
      n_checks++;
      if (got !== ex) begin
        n_err++;
        $display("FAIL no_stall[%0d] got=%h exp=%h", i, got, ex);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_md_dep();
    row_t rows[$];
    obs_t got, ex;
    rows = '{r(st(0, 0, 0, 0, 0, 0, 0, 0, 1), PASS), r(st(0, 0, 0, 0, 0, 0, 1, 1, 0), PASS),
             r(st(0, 0, 0, 0, 0, 0, 0, 1, 0), STALL | BUSY), r(st(0, 0, 0, 0, 0, 0, 0, 1, 0), STALL | BUSY),
             r(st(0, 0, 0, 0, 0, 0, 0, 1, 0), STALL | BUSY), r(st(0, 0, 0, 0, 0, 0, 0, 1, 0), PASS | BUSY | DONE),
             r(st(0, 0, 0, 0, 0, 0, 0, 1, 0), PASS)};
    foreach (rows[i]) begin
      apply(rows[i].s);
      predict(rows[i].e, rows[i].s.clr);
      @(negedge clk);
      got = obs();
      ex = q.pop_front();
      n_checks++;
      if (got !== ex) begin
        n_err++;
        $display("FAIL md_dep[%0d] got=%h exp=%h", i, got, ex);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    row_t rows[$];
    obs_t got, ex;
    rows = '{r(st(1, 5, 5, 0, 0, 1, 1, 0, 0), FLUSH), r(st(0, 0, 0, 0, 0, 0, 0, 0, 0), PASS),
             r(st(1, 6, 2, 6, 1, 1, 0, 0, 0), FLUSH), r(st(0, 0, 0, 0, 0, 0, 0, 0, 0), PASS)};
    foreach (rows[i]) begin
      apply(rows[i].s);
      predict(rows[i].e, rows[i].s.clr);
      @(negedge clk);
      got = obs();
      ex = q.pop_front();
      n_checks++;
      if (got !== ex) begin
        n_err++;
        $display("FAIL branch[%0d] got=%h exp=%h", i, got, ex);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    obs_t got, ex;
    rows = '{r(st(0, 0, 0, 0, 0, 0, 1, 0, 0), PASS), r(st(0, 0, 0, 0, 0, 1, 0, 1, 0), FLUSH | BUSY),
             r(st(0, 0, 0, 0, 0, 0, 0, 1, 0), STALL | BUSY), r(st(0, 0, 0, 0, 0, 0, 0, 1, 0), STALL | BUSY),
             r(st(0, 0, 0, 0, 0, 0, 0, 1, 0), PASS | BUSY | DONE), r(st(0, 0, 0, 0, 0, 0, 1, 0, 0), PASS),
             r(st(0, 0, 0, 0, 0, 0, 0, 0, 0), PASS | BUSY), r(st(0, 0, 0, 0, 0, 0, 0, 0, 0), PASS | BUSY),
             r(st(0, 0, 0, 0, 0, 0, 0, 0, 0), PASS | BUSY), r(st(0, 0, 0, 0, 0, 0, 0, 0, 0), PASS | BUSY | DONE),
             r(st(0, 0, 0, 0, 0, 0, 0, 0, 0), PASS)};
    foreach (rows[i]) begin
      apply(rows[i].s);
      predict(rows[i].e, rows[i].s.clr);
      @(negedge clk);
      got = obs();
      ex = q.pop_front();
      n_checks++;
      if (got !== ex) begin
        n_err++;
        $display("FAIL back_to_back[%0d] got=%h exp=%h", i, got, ex);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_md();
    row_t rows[$];
    obs_t got, ex;
    rows = '{r(st(0, 0, 0, 0, 0, 0, 1, 0, 0), PASS), r(st(0, 0, 0, 0, 0, 0, 0, 0, 0), PASS | BUSY)};
    foreach (rows[i]) begin
      apply(rows[i].s);
      predict(rows[i].e, rows[i].s.clr);
      @(negedge clk);
      got = obs();
      ex = q.pop_front();
      n_checks++;
      if (got !== ex) begin
        n_err++;
        $display("FAIL reset_mid_md[%0d] got=%h exp=%h", i, got, ex);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    predict(STALL, 1'b0);
    #1;
    got = obs();
    ex = q.pop_front();
    n_checks++;
    if (got !== ex) begin
      n_err++;
      $display("FAIL reset_mid_md_abort got=%h exp=%h", got, ex);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    rows = '{r(st(0, 0, 0, 0, 0, 0, 0, 0, 0), PASS), r(st(0, 0, 0, 0, 0, 0, 0, 0, 0), PASS),
             r(st(0, 0, 0, 0, 0, 0, 0, 0, 0), PASS), r(st(0, 0, 0, 0, 0, 0, 0, 0, 0), PASS)};
    foreach (rows[i]) begin
      apply(rows[i].s);
      predict(rows[i].e, rows[i].s.clr);
      @(negedge clk);
      got = obs();
      ex = q.pop_front();
      n_checks++;
      if (got !== ex) begin
        n_err++;
        $display("FAIL reset_mid_md_after[%0d] got=%h exp=%h", i, got, ex);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturate();
    row_t rows[$];
    obs_t got, ex;
    stim_t lu;
    lu = st(1, 5, 5, 0, 0, 0, 0, 0, 0);
    apply(lu);
    repeat (65535) @(posedge clk);
    #1;
    exp_sc = (exp_sc > 16'd0) ? 16'hFFFF : 16'd65535;
    rows = '{r(lu, STALL), r(lu, STALL), r(st(1, 5, 5, 0, 0, 0, 0, 0, 1), STALL),
             r(st(0, 0, 0, 0, 0, 0, 0, 0, 0), PASS), r(lu, STALL), r(st(0, 0, 0, 0, 0, 0, 0, 0, 0), PASS)};
    foreach (rows[i]) begin
      apply(rows[i].s);
      predict(rows[i].e, rows[i].s.clr);
      @(negedge clk);
      got = obs();
      ex = q.pop_front();
      n_checks++;
      if (got !== ex) begin
        n_err++;
        $display("FAIL saturate[%0d] got=%h exp=%h", i, got, ex);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    exp_sc   = 16'd0;
    reset    = 1'b0;
    apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_no_stall();
    test_md_dep();
    test_branch();
    test_back_to_back();
    test_reset_mid_md();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage MIPS datapath. It decides each cycle whether the PC and IF/ID register advance, whether IF/ID is flushed, and which 14-bit control word is presented to the ID/EX register (real decode output or bubble). It covers three hazards: load-use, taken-branch flush, and a multi-cycle multiply/divide unit it tracks with a busy counter. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
- MD_LATENCY, 32, cycles the mult/div unit is busy after issue; legal 1..64
- BUBBLE_CTRL, 14'h0001, control word injected into ID/EX for a bubble; same value ID/EX loads on reset
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- id_ex_memread  in  1  instruction in EX is a load
- id_ex_rt  in  5  destination rt of the instruction in EX
- if_id_rs  in  5  rs field of the instruction in ID
- if_id_rt  in  5  rt field of the instruction in ID
- if_id_uses_rt  in  1  instruction in ID reads rt as a source
- branch_taken  in  1  branch resolved taken in EX this cycle
- md_start  in  1  instruction in ID is mult/div
- if_id_md_use  in  1  instruction in ID needs HI/LO or the md unit (mfhi, mflo, mult, div)
- ctrl_in  in  14  decoded control word from ID
- stall_clr  in  1  synchronous clear of stall_cnt
- pc_write  out  1  PC register load enable
- if_id_write  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID loads a NOP
- id_ex_ctrl  out  14  control word to ID/EX: ctrl_in or BUBBLE_CTRL
- md_busy  out  1  mult/div unit busy
- md_done  out  1  one-cycle pulse in the final busy cycle
- stall_cnt  out  16  saturating count of stalled cycles

## Operation
- FSM states: RUN, MD_BUSY. The state, a 6-bit md counter and stall_cnt are registered. All other outputs are combinational from state and inputs.
- load_hz = id_ex_memread & (id_ex_rt != 0) & ((id_ex_rt == if_id_rs) | (if_id_uses_rt & (id_ex_rt == if_id_rt))).
- md_hz = (state == MD_BUSY) & if_id_md_use & ~md_done.
- Priority is branch, then md_hz, then load_hz.
- If branch_taken: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_ctrl=BUBBLE_CTRL. Stalls are overridden. No md issue this cycle, even if md_start=1.
- Else if md_hz or load_hz (stall): pc_write=0, if_id_write=0, if_id_flush=0, id_ex_ctrl=BUBBLE_CTRL.
- Else: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_ctrl=ctrl_in.
- MD issue happens in RUN when md_start=1, no branch and no stall. The counter loads MD_LATENCY-1 and the next state is MD_BUSY.
- MD_BUSY: md_busy=1. The counter decrements each cycle. When counter==0: md_done=1, next state RUN.
- branch_taken in MD_BUSY flushes as normal; the counter keeps running.
- stall_cnt: stall_clr=1 clears it to 0 (clear has priority over increment). Otherwise it increments when if_id_write==0 and holds at 16'hFFFF.

## Timing
- While reset is low and at release: state=RUN, counter=0, stall_cnt=0, md_busy=0, md_done=0, if_id_flush=0.
- While reset is low, outputs are forced: pc_write=0, if_id_write=0, id_ex_ctrl=BUBBLE_CTRL.
- Reset asserted mid-MD_BUSY aborts the operation immediately. No md_done pulse is generated.
- Load-use: exactly 1 stall cycle. On the next edge the load leaves EX and the bubble enters EX, so load_hz drops.
- MD: md_start accepted at edge N gives md_busy=1 for cycles N+1 .. N+MD_LATENCY, with md_done in cycle N+MD_LATENCY. A dependent instruction in ID issues in cycle N+MD_LATENCY, because md_done masks md_hz.
- With MD_LATENCY=1, md_busy and md_done are both high for the single cycle N+1.
- Branch flush: IF/ID and ID/EX receive NOPs at the same edge the PC loads the target. The penalty is 2 cycles.
- If a load-use stall and branch_taken coincide, the branch wins and the stalled ID instruction is discarded.

## Test plan
- **Load-use stall.** Drive id_ex_memread=1, id_ex_rt=5, if_id_rs=5. Required for 1 cycle: pc_write=0, id_ex_ctrl=14'h0001. Then ctrl_in passes through and stall_cnt=1.
- **No stall on $0 or unused rt.** id_ex_rt=0 with if_id_rs=0 gives no stall. id_ex_rt=7, if_id_rt=7, if_id_uses_rt=0 also gives no stall.
- **MD dependency.** MD_LATENCY=4: md_start pulse, then if_id_md_use=1 held. Required: md_busy for 4 cycles, md_done in the 4th, and the dependent instruction stalled 3 cycles. stall_cnt=3.
- **Branch beats stall.** branch_taken=1 together with load_hz=1. Required: pc_write=1, if_id_flush=1, id_ex_ctrl=BUBBLE_CTRL. stall_cnt unchanged.
- **Reset mid-MD and counter edges.** Assert reset in the 2nd busy cycle. Required: md_busy=0 at once and no md_done afterward. Separately, preload stall_cnt to 16'hFFFF, stall again and confirm it holds. stall_clr together with a stall gives 0.
